y86_fetch_unit: RTL and testbench

- Multi-cycle fetch stage of the Y86-64 SEQ core.
- Accepts the PC produced by the PC-update stage and reads the instruction one byte at a time from a byte-wide instruction memory.
- Decodes the split/align fields, computes valP and instruction status.
- Presents the fetched instruction to decode through a valid/ready handshake.
- Its icode, valC and valP outputs are the values the PC-update stage consumes on the next instruction.

---
 rtl/y86_fetch_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_y86_fetch_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : y86_fetch_unit
// Purpose  : Byte-serial Y86-64 fetch stage with split/align decode and a
//            valid/ready hand-off to decode.
// Revision : 1.0
// ============================================================================
module y86_fetch_unit #(
    parameter int unsigned IMEM_SIZE = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [7:0]  imem_rdata_i,
    input  logic        imem_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  rA_o,
    output logic [3:0]  rB_o,
    output logic [63:0] valC_o,
    output logic [63:0] valP_o,
    output logic [2:0]  stat_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BYTE0 = 3'd1,
        S_REGS  = 3'd2,
        S_CONST = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 4'd4;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  k_q, k_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic [2:0]  stat_q, stat_d;

    logic [64:0] w_addr_ext;
    logic [63:0] w_addr;
    logic [63:0] w_next;
    logic        w_addr_bad;
    logic        w_fetch;
    logic        w_start;
    logic [3:0]  w_hi;
    logic [3:0]  w_lo;

    function automatic logic ifun_legal(input logic [3:0] ic, input logic [3:0] fn);
        case (ic)
            I_OPQ:           return fn <= 4'd3;
            I_JXX, I_RRMOVQ: return fn <= 4'd6;
            default:         return fn == 4'd0;
        endcase
    endfunction

    // Carry out of the 65-bit sum flags a wrapped address as illegal.
    assign w_addr_ext = {1'b0, pc_q} + {61'd0, k_q};
    assign w_addr     = w_addr_ext[63:0];
    assign w_next     = w_addr + 64'd1;
    assign w_addr_bad = w_addr_ext[64] | (w_addr >= 64'(IMEM_SIZE));
    assign w_fetch    = (state_q == S_BYTE0) || (state_q == S_REGS) || (state_q == S_CONST);
    assign w_hi       = imem_rdata_i[7:4];
    assign w_lo       = imem_rdata_i[3:0];

    assign imem_req_o    = w_fetch & ~w_addr_bad;
    assign imem_addr_o   = w_fetch ? w_addr : 64'd0;
    assign pc_ready_o    = (state_q == S_IDLE) || ((state_q == S_DONE) && instr_ready_i);
    assign instr_valid_o = (state_q == S_DONE);
    assign icode_o       = icode_q;
    assign ifun_o        = ifun_q;
    assign rA_o          = ra_q;
    assign rB_o          = rb_q;
    assign valC_o        = valc_q;
    assign valP_o        = valp_q;
    assign stat_o        = stat_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        stat_d  = stat_q;
        w_start = 1'b0;

        case (state_q)
            S_IDLE: w_start = pc_valid_i;
            S_DONE: begin
                if (instr_ready_i) begin
                    state_d = S_IDLE;
                    w_start = pc_valid_i;
                end
            end
            S_BYTE0, S_REGS, S_CONST: begin
                if (w_addr_bad) begin
                    stat_d  = STAT_ADR;
                    valp_d  = w_addr;
                    state_d = S_DONE;
                end else if (imem_rvalid_i) begin
                    k_d = k_q + 4'd1;
                    if (imem_err_i) begin
                        stat_d  = STAT_ADR;
                        valp_d  = w_addr;
                        state_d = S_DONE;
                    end else if (state_q == S_BYTE0) begin
                        icode_d = w_hi;
                        ifun_d  = w_lo;
                        if ((w_hi > I_POPQ) || !ifun_legal(w_hi, w_lo)) begin
                            stat_d  = STAT_INS;
                            valp_d  = w_next;
                            state_d = S_DONE;
                        end else begin
                            case (w_hi)
                                I_HALT: begin
                                    stat_d  = STAT_HLT;
                                    valp_d  = w_next;
                                    state_d = S_DONE;
                                end
                                I_NOP, I_RET: begin
                                    valp_d  = w_next;
                                    state_d = S_DONE;
                                end
                                I_JXX, I_CALL: state_d = S_CONST;
                                default:       state_d = S_REGS;
                            endcase
                        end
                    end else if (state_q == S_REGS) begin
                        ra_d = w_hi;
                        rb_d = w_lo;
                        if (icode_q inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) begin
                            state_d = S_CONST;
                        end else begin
                            valp_d  = w_next;
                            state_d = S_DONE;
                        end
                    end else begin
                        valc_d[{cnt_q, 3'b000} +: 8] = imem_rdata_i;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            valp_d  = w_next;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new pc can land in the DONE handshake cycle, skipping IDLE.
        if (w_start) begin
            state_d = S_BYTE0;
            pc_d    = pc_i;
            k_d     = 4'd0;
            cnt_d   = 3'd0;
            icode_d = 4'h0;
            ifun_d  = 4'h0;
            ra_d    = 4'hF;
            rb_d    = 4'hF;
            valc_d  = 64'd0;
            valp_d  = 64'd0;
            stat_d  = STAT_AOK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= 64'd0;
            k_q     <= 4'd0;
            cnt_q   <= 3'd0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
            stat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            stat_q  <= stat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_fetch_unit
// Purpose  : Self-checking bench for y86_fetch_unit against a byte-level model.
// Revision : 1.0
// ============================================================================
module tb_y86_fetch_unit;

    localparam int unsigned IMEM_SIZE = 4096;

    logic        clk;
    logic        rst_n_i;
    logic [63:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [7:0]  imem_rdata_i;
    logic        imem_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
    logic [63:0] valC_o, valP_o;
    logic [2:0]  stat_o;

    y86_fetch_unit #(.IMEM_SIZE(IMEM_SIZE)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
        .pc_ready_o(pc_ready_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .icode_o(icode_o), .ifun_o(ifun_o), .rA_o(rA_o), .rB_o(rB_o),
        .valC_o(valC_o), .valP_o(valP_o), .stat_o(stat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        int          nbytes;
        bit          fault;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [IMEM_SIZE];
    bit          fault_at [logic [63:0]];
    logic [63:0] consumed [$];
    int          unstable_cnt = 0;
    int          bad_req_cnt  = 0;
    int          fixed_lat    = 0;
    bit          rand_lat     = 0;
    bit          spur_en      = 0;

    // Memory responder: answers each request after a chosen wait, logs
    // consumed addresses, and optionally injects rvalid noise when idle.
    initial begin
        bit          pending;
        logic [63:0] pend_addr;
        int          wait_cnt, cur_lat;
        pending = 0; pend_addr = 0; wait_cnt = 0; cur_lat = 0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 8'h00; imem_err_i = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req_o === 1'b1) begin
                if (!pending) begin
                    pending   = 1;
                    pend_addr = imem_addr_o;
                    wait_cnt  = 0;
                    cur_lat   = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
                end else if (imem_addr_o !== pend_addr) begin
                    unstable_cnt++;
                end
                if (imem_addr_o >= 64'(IMEM_SIZE)) bad_req_cnt++;
                if (wait_cnt >= cur_lat) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = (imem_addr_o < 64'(IMEM_SIZE)) ? mem[imem_addr_o[11:0]] : 8'h00;
                    imem_err_i    = fault_at.exists(imem_addr_o);
                    consumed.push_back(imem_addr_o);
                    pending = 0;
                end else begin
                    imem_rvalid_i = 1'b0;
                    imem_rdata_i  = 8'($urandom);
                    imem_err_i    = 1'($urandom % 2);
                    wait_cnt++;
                end
            end else begin
                pending       = 0;
                imem_rvalid_i = spur_en ? 1'($urandom % 2) : 1'b0;
                imem_rdata_i  = 8'($urandom);
                imem_err_i    = 1'($urandom % 2);
            end
        end
    end

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            default:                return 10;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] ic, input logic [3:0] fn);
        if (ic > 4'hB) return 0;
        if (ic == 4'h6) return fn < 4'd4;
        if (ic == 4'h7 || ic == 4'h2) return fn < 4'd7;
        return fn == 4'd0;
    endfunction

    function automatic bit in_range(input logic [63:0] pc, input int k);
        logic [64:0] a;
        a = {1'b0, pc} + 65'(k);
        return a < 65'(IMEM_SIZE);
    endfunction

    // Walks the instruction byte by byte as the ISA defines it.
    function automatic exp_t model(input logic [63:0] pc);
        exp_t        e;
        logic [7:0]  b;
        logic [63:0] a;
        int          len;
        bit          regs;
        e.icode = 0; e.ifun = 0; e.ra = 4'hF; e.rb = 4'hF; e.valc = 0;
        e.valp = pc; e.stat = 3'd1; e.nbytes = 0; e.fault = 0;
        if (!in_range(pc, 0)) begin e.stat = 3'd3; return e; end
        e.nbytes = 1;
        if (fault_at.exists(pc)) begin e.stat = 3'd3; e.fault = 1; return e; end
        b = mem[pc[11:0]];
        e.icode = b[7:4]; e.ifun = b[3:0]; e.valp = pc + 64'd1;
        if (!legal(e.icode, e.ifun)) begin e.stat = 3'd4; return e; end
        len  = ilen(e.icode);
        regs = (len == 2) || (len == 10);
        for (int k = 1; k < len; k++) begin
            a = pc + 64'(k);
            if (!in_range(pc, k)) begin e.stat = 3'd3; e.valp = a; e.nbytes = k; return e; end
            e.nbytes = k + 1;
            if (fault_at.exists(a)) begin e.stat = 3'd3; e.fault = 1; return e; end
            b = mem[a[11:0]];
            if (regs && k == 1) begin e.ra = b[7:4]; e.rb = b[3:0]; end
            else e.valc[8*(k - (regs ? 2 : 1)) +: 8] = b;
        end
        e.valp = pc + 64'(len);
        e.stat = (e.icode == 4'h0) ? 3'd2 : 3'd1;
        return e;
    endfunction

    // Issues one pc from IDLE, waits for instr_valid_o, holds ready low for
    // 'hold' cycles, then completes the handshake.
    task automatic fetch(input logic [63:0] pc, input int hold, output exp_t o,
                         output int lat, output bit tmo, output int hold_bad);
        consumed.delete();
        @(negedge clk);
        pc_i = pc; pc_valid_i = 1'b1; instr_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pc_valid_i = 1'b0; pc_i = {$urandom, $urandom};
        lat = 1;
        while (instr_valid_o !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
        tmo = (instr_valid_o !== 1'b1);
        o.icode = icode_o; o.ifun = ifun_o; o.ra = rA_o; o.rb = rB_o;
        o.valc = valC_o; o.valp = valP_o; o.stat = stat_o; o.nbytes = 0; o.fault = 0;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1 ||
                {icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o, stat_o} !==
                {o.icode, o.ifun, o.ra, o.rb, o.valc, o.valp, o.stat}) hold_bad++;
        end
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if ({pc_ready_o, instr_valid_o, imem_req_o} !== 3'b100) begin
            bad++; $display("FAIL reset_ctrl got=%b want=100", {pc_ready_o, instr_valid_o, imem_req_o}); end
        total++; if ({icode_o, ifun_o, rA_o, rB_o} !== 16'h00FF) begin
            bad++; $display("FAIL reset_fields got=%h want=00ff", {icode_o, ifun_o, rA_o, rB_o}); end
        total++; if ({valC_o, valP_o, stat_o, imem_addr_o} !== '0) begin
            bad++; $display("FAIL reset_vals got=%h/%h/%h/%h want=0", valC_o, valP_o, stat_o, imem_addr_o); end
    endtask

    task automatic test_irmovq();
        exp_t o; int lat, hb; bit tmo;
        logic [7:0] bytes [10] = '{8'h30, 8'hF0, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        for (int i = 0; i < 10; i++) mem[12'h100 + 12'(i)] = bytes[i];
        fixed_lat = 0;
        fetch(64'h100, 0, o, lat, tmo, hb);
        total++; if (tmo || lat != 11) begin bad++; $display("FAIL irmovq_latency got=%0d want=11", lat); end
        total++; if ({o.icode, o.ifun, o.ra, o.rb} !== 16'h30F0) begin
            bad++; $display("FAIL irmovq_fields got=%h want=30f0", {o.icode, o.ifun, o.ra, o.rb}); end
        total++; if (o.valc !== 64'h0123456789ABCDEF) begin
            bad++; $display("FAIL irmovq_valc got=%h want=0123456789abcdef", o.valc); end
        total++; if (o.valp !== 64'h10A || o.stat !== 3'd1) begin
            bad++; $display("FAIL irmovq_valp_stat got=%h/%0d want=10a/1", o.valp, o.stat); end
        for (int i = 0; i < 10; i++) begin
            total++; if (consumed.size() <= i || consumed[i] !== 64'h100 + 64'(i)) begin
                bad++; $display("FAIL irmovq_addr%0d got=%h want=%h", i,
                                (consumed.size() > i) ? consumed[i] : 64'hX, 64'h100 + 64'(i)); end
        end
    endtask

    task automatic test_halt_delay();
        exp_t o; int lat, hb; bit tmo;
        mem[12'h020] = 8'h00;
        fixed_lat = 3; unstable_cnt = 0;
        fetch(64'h20, 0, o, lat, tmo, hb);
        fixed_lat = 0;
        total++; if (tmo || lat != 5) begin bad++; $display("FAIL halt_latency got=%0d want=5", lat); end
        total++; if (o.stat !== 3'd2 || o.valp !== 64'h21) begin
            bad++; $display("FAIL halt_stat_valp got=%0d/%h want=2/21", o.stat, o.valp); end
        total++; if (unstable_cnt != 0 || consumed.size() != 1 || consumed[0] !== 64'h20) begin
            bad++; $display("FAIL halt_addr_stable got=%0d changes want=0", unstable_cnt); end
    endtask

    task automatic test_jxx_stall();
        exp_t o; int lat, hb; bit tmo;
        logic [7:0] bytes [9] = '{8'h73, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) mem[12'h040 + 12'(i)] = bytes[i];
        fetch(64'h40, 4, o, lat, tmo, hb);
        total++; if (tmo || {o.icode, o.ifun, o.ra, o.rb} !== 16'h73FF) begin
            bad++; $display("FAIL jxx_fields got=%h want=73ff", {o.icode, o.ifun, o.ra, o.rb}); end
        total++; if (o.valc !== 64'h200 || o.valp !== 64'h49 || o.stat !== 3'd1) begin
            bad++; $display("FAIL jxx_vals got=%h/%h/%0d want=200/49/1", o.valc, o.valp, o.stat); end
        total++; if (hb != 0) begin bad++; $display("FAIL jxx_stall_stable got=%0d want=0", hb); end
    endtask

    task automatic test_errors();
        exp_t o; int lat, hb; bit tmo;
        mem[12'hFFE] = 8'h30; mem[12'hFFF] = 8'hF0;
        bad_req_cnt = 0;
        fetch(64'(IMEM_SIZE - 2), 0, o, lat, tmo, hb);
        total++; if (tmo || o.stat !== 3'd3 || o.valp !== 64'(IMEM_SIZE)) begin
            bad++; $display("FAIL adr_end got=%0d/%h want=3/%h", o.stat, o.valp, 64'(IMEM_SIZE)); end
        total++; if (consumed.size() != 2 || bad_req_cnt != 0) begin
            bad++; $display("FAIL adr_no_req got=%0d/%0d want=2/0", consumed.size(), bad_req_cnt); end
        fetch(64'hFFFF_FFFF_FFFF_FFFF, 0, o, lat, tmo, hb);
        total++; if (tmo || o.stat !== 3'd3 || o.valp !== 64'hFFFF_FFFF_FFFF_FFFF || consumed.size() != 0) begin
            bad++; $display("FAIL adr_k0 got=%0d/%h/%0d want=3/ffffffffffffffff/0", o.stat, o.valp, consumed.size()); end
        mem[12'h300] = 8'hF0;
        fetch(64'h300, 0, o, lat, tmo, hb);
        total++; if (tmo || o.stat !== 3'd4 || o.valp !== 64'h301) begin
            bad++; $display("FAIL ins_icode got=%0d/%h want=4/301", o.stat, o.valp); end
        mem[12'h310] = 8'h67;
        fetch(64'h310, 0, o, lat, tmo, hb);
        total++; if (tmo || o.stat !== 3'd4 || o.valp !== 64'h311) begin
            bad++; $display("FAIL ins_ifun got=%0d/%h want=4/311", o.stat, o.valp); end
        mem[12'h320] = 8'hA0; mem[12'h321] = 8'h0F;
        fault_at[64'h321] = 1;
        fetch(64'h320, 0, o, lat, tmo, hb);
        fault_at.delete();
        total++; if (tmo || o.stat !== 3'd3 || consumed.size() != 2) begin
            bad++; $display("FAIL mem_fault got=%0d/%0d want=3/2", o.stat, consumed.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h12;
        @(negedge clk);
        pc_i = 64'h0; pc_valid_i = 1'b1; instr_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_i = 64'h1;
        n = 1;
        while (instr_valid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++; if (instr_valid_o !== 1'b1 || icode_o !== 4'h1 || valP_o !== 64'h1 || pc_ready_o !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%b/%h/%h/%b want=1/1/1/1", instr_valid_o, icode_o, valP_o, pc_ready_o); end
        @(posedge clk);
        @(negedge clk);
        pc_valid_i = 1'b0;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h1 || instr_valid_o !== 1'b0) begin
            bad++; $display("FAIL b2b_no_bubble got=%b/%h/%b want=1/1/0", imem_req_o, imem_addr_o, instr_valid_o); end
        n = 1;
        while (instr_valid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++; if ({instr_valid_o, icode_o, ifun_o, rA_o, rB_o, stat_o} !== {1'b1, 16'h2012, 3'd1} || valP_o !== 64'h3) begin
            bad++; $display("FAIL b2b_second got=%h/%h/%0d want=2012/3/1", {icode_o, ifun_o, rA_o, rB_o}, valP_o, stat_o); end
        @(negedge clk);
        instr_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_const();
        exp_t o, e; int lat, hb; bit tmo;
        mem[12'h500] = 8'h30; mem[12'h501] = 8'hF3;
        for (int i = 2; i < 10; i++) mem[12'h500 + 12'(i)] = 8'(8'h10 + i);
        fixed_lat = 0;
        @(negedge clk);
        pc_i = 64'h500; pc_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h505) begin
            bad++; $display("FAIL midrst_pre got=%b/%h want=1/505", imem_req_o, imem_addr_o); end
        #1 rst_n_i = 1'b0;
        #1;
        total++; if ({imem_req_o, instr_valid_o, pc_ready_o} !== 3'b001) begin
            bad++; $display("FAIL midrst_async got=%b want=001", {imem_req_o, instr_valid_o, pc_ready_o}); end
        @(negedge clk);
        rst_n_i = 1'b1;
        e = model(64'h500);
        fetch(64'h500, 0, o, lat, tmo, hb);
        total++; if (tmo || {o.icode, o.ifun, o.ra, o.rb, o.valc, o.valp, o.stat} !==
                            {e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat}) begin
            bad++; $display("FAIL midrst_after got=%h/%h/%h want=%h/%h/%h", {o.icode, o.ifun, o.ra, o.rb},
                            o.valc, o.valp, {e.icode, e.ifun, e.ra, e.rb}, e.valc, e.valp); end
    endtask

    task automatic test_random();
        exp_t o, e; int lat, hb; bit tmo;
        logic [63:0] pc, a;
        logic [3:0]  ic, fn;
        rand_lat = 1; spur_en = 1; unstable_cnt = 0; bad_req_cnt = 0;
        for (int it = 0; it < 40; it++) begin
            pc = ($urandom % 4 == 0) ? 64'(IMEM_SIZE - 1 - $urandom_range(0, 10))
                                     : 64'($urandom_range(0, IMEM_SIZE - 1));
            ic = ($urandom % 8 == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            if ($urandom % 6 == 0)                fn = 4'($urandom);
            else if (ic == 4'h6)                  fn = 4'($urandom_range(0, 3));
            else if (ic == 4'h7 || ic == 4'h2)    fn = 4'($urandom_range(0, 6));
            else                                  fn = 4'h0;
            for (int j = 0; j < 10; j++) begin
                a = pc + 64'(j);
                if (a < 64'(IMEM_SIZE)) mem[a[11:0]] = (j == 0) ? {ic, fn} : 8'($urandom);
            end
            fault_at.delete();
            if ($urandom % 8 == 0) fault_at[pc + 64'($urandom_range(0, 9))] = 1;
            e = model(pc);
            fetch(pc, $urandom_range(0, 3), o, lat, tmo, hb);
            total++; if (tmo || o.stat !== e.stat || consumed.size() != e.nbytes) begin
                bad++; $display("FAIL rand%0d_stat pc=%h got=%0d/%0d want=%0d/%0d", it, pc,
                                o.stat, consumed.size(), e.stat, e.nbytes); end
            if (!e.fault) begin
                total++; if (o.valp !== e.valp) begin
                    bad++; $display("FAIL rand%0d_valp pc=%h got=%h want=%h", it, pc, o.valp, e.valp); end
            end
            if (e.stat == 3'd1 || e.stat == 3'd2) begin
                total++; if ({o.icode, o.ifun, o.ra, o.rb} !== {e.icode, e.ifun, e.ra, e.rb} || o.valc !== e.valc) begin
                    bad++; $display("FAIL rand%0d_fields pc=%h got=%h/%h want=%h/%h", it, pc,
                                    {o.icode, o.ifun, o.ra, o.rb}, o.valc, {e.icode, e.ifun, e.ra, e.rb}, e.valc); end
            end
            total++; if (hb != 0) begin bad++; $display("FAIL rand%0d_hold got=%0d want=0", it, hb); end
        end
        fault_at.delete();
        rand_lat = 0; spur_en = 0;
        total++; if (unstable_cnt != 0 || bad_req_cnt != 0) begin
            bad++; $display("FAIL rand_req_rules got=%0d/%0d want=0/0", unstable_cnt, bad_req_cnt); end
    endtask

    initial begin
        rst_n_i = 1'b0; pc_i = 64'd0; pc_valid_i = 1'b0; instr_ready_i = 1'b0;
        for (int i = 0; i < IMEM_SIZE; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        test_reset();
        test_irmovq();
        test_halt_delay();
        test_jxx_stall();
        test_errors();
        test_back_to_back();
        test_reset_mid_const();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
